// File: rtl/hsi_msg_arbiter.sv
// ============================================================================
// hsi_msg_arbiter
// ----------------------------------------------------------------------------
// N-source message arbiter/sequencer for the HSI master transmit path.
// One pending source is granted at a time. Its bytes are forwarded to the
// coder with one cycle of latency, a CRC-16-CCITT is accumulated over the
// payload, and the CRC is appended high byte first. A granted source that
// goes quiet for too long, or strobes a byte while back-pressured, aborts
// the message with an err pulse.
//
// Build option:
//   HSI_ARB_RR_EN  defined   -> round-robin arbitration (search starts at
//                               the rr pointer; pointer moves past winner)
//                  undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk          in   1          system clock, rising edge
//   rst          in   1          asynchronous reset, active-high
//   src_req      in   N_SRC      source has a message pending (level)
//   src_d        in   8*N_SRC    source bytes, source i on [8i+7:8i]
//   src_d_rdy    in   N_SRC      1-cycle strobe: src_d byte valid
//   src_msg_end  in   N_SRC      1-cycle strobe: source's last byte delivered
//   src_grant    out  N_SRC      one-hot grant, held for whole message + CRC
//   src_busy     out  N_SRC      per-source back-pressure
//   cd_busy      in   1          coder serialising a byte
//   cd_d         out  8          byte to coder
//   cd_d_rdy     out  1          1-cycle registered strobe to coder
//   grant_idx    out  IDX_W      index of granted source (valid while busy)
//   busy         out  1          message in progress
//   msg_end      out  1          1-cycle pulse with the CRC low byte strobe
//   err          out  1          1-cycle pulse on timeout or overrun abort
// ============================================================================
//
// state  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | no message; pick a winner from src_req and register its grant
// GRANT  | one cycle; preset CRC and timeout counter
// XFER   | forward granted source's bytes, watch for end/timeout/overrun
// CRC_HI | wait for coder idle, issue crc[15:8]
// CRC_LO | wait for coder idle, issue crc[7:0], pulse msg_end
// GUARD  | one cycle with grant dropped so src_req is re-sampled fresh
// ============================================================================

module hsi_msg_arbiter #(
    parameter int          N_SRC    = 4,
    parameter int          IDX_W    = 3,
    parameter int          TIMEOUT  = 1024,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   src_req,
    input  logic [8*N_SRC-1:0] src_d,
    input  logic [N_SRC-1:0]   src_d_rdy,
    input  logic [N_SRC-1:0]   src_msg_end,
    output logic [N_SRC-1:0]   src_grant,
    output logic [N_SRC-1:0]   src_busy,
    input  logic               cd_busy,
    output logic [7:0]         cd_d,
    output logic               cd_d_rdy,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output logic               msg_end,
    output logic               err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GRANT  = 3'd1;
    localparam logic [2:0] ST_XFER   = 3'd2;
    localparam logic [2:0] ST_CRC_HI = 3'd3;
    localparam logic [2:0] ST_CRC_LO = 3'd4;
    localparam logic [2:0] ST_GUARD  = 3'd5;

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [15:0]      crc;
    logic [CNT_W-1:0] tmo_cnt;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [N_SRC-1:0] win_oh;

    logic [7:0]       g_byte;
    logic             g_rdy;
    logic             g_end;
    logic             cd_free;
    logic             g_accept;
    logic             g_overrun;

`ifdef HSI_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic             up_found;
    logic [IDX_W-1:0] up_idx;
`endif

    // Byte-parallel CRC-16-CCITT step (poly 0x1021, MSB first, no reflection).
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int b = 0; b < 8; b++) begin
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // Winner selection. Round-robin is done as two lowest-index searches:
    // one restricted to indices at/after the pointer, one unrestricted as
    // the wrap-around fallback.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef HSI_ARB_RR_EN
        up_found  = 1'b0;
        up_idx    = '0;
`endif
        for (int i = 0; i < N_SRC; i++) begin
            if (src_req[i] && !win_found) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
`ifdef HSI_ARB_RR_EN
            if (src_req[i] && !up_found && (IDX_W'(i) >= rr_ptr)) begin
                up_found = 1'b1;
                up_idx   = IDX_W'(i);
            end
`endif
        end
`ifdef HSI_ARB_RR_EN
        if (up_found) begin
            win_idx = up_idx;
        end
`endif
        win_oh = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (win_found && (win_idx == IDX_W'(i))) begin
                win_oh[i] = 1'b1;
            end
        end
    end

    // Granted-source views; the one-hot grant doubles as the select.
    always_comb begin
        g_byte = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_grant[i]) begin
                g_byte = src_d[8*i +: 8];
            end
        end
    end

    assign g_rdy     = |(src_d_rdy & src_grant);
    assign g_end     = |(src_msg_end & src_grant);
    // cd_d_rdy is included because the coder only raises cd_busy the cycle
    // after it sees the strobe.
    assign cd_free   = ~(cd_busy | cd_d_rdy);
    assign g_accept  = (state == ST_XFER) && g_rdy && cd_free;
    assign g_overrun = (state == ST_XFER) && g_rdy && !cd_free;

    always_comb begin
        if (state == ST_XFER) begin
            src_busy = ~src_grant | {N_SRC{~cd_free}};
        end else begin
            src_busy = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            src_grant <= '0;
            cd_d      <= '0;
            cd_d_rdy  <= 1'b0;
            grant_idx <= '0;
            busy      <= 1'b0;
            msg_end   <= 1'b0;
            err       <= 1'b0;
            crc       <= CRC_INIT;
            tmo_cnt   <= '0;
        end else begin
            cd_d_rdy <= 1'b0;
            msg_end  <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        src_grant <= win_oh;
                        grant_idx <= win_idx;
                        busy      <= 1'b1;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    crc     <= CRC_INIT;
                    tmo_cnt <= '0;
                    state   <= ST_XFER;
                end
                ST_XFER: begin
                    if (g_overrun) begin
                        err       <= 1'b1;
                        src_grant <= '0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        if (g_accept) begin
                            cd_d     <= g_byte;
                            cd_d_rdy <= 1'b1;
                            crc      <= crc16_byte(crc, g_byte);
                            tmo_cnt  <= '0;
                        end
                        if (g_end) begin
                            state <= ST_CRC_HI;
                        end else if (!g_accept) begin
                            if (tmo_cnt == TMO_LAST) begin
                                err       <= 1'b1;
                                src_grant <= '0;
                                busy      <= 1'b0;
                                state     <= ST_IDLE;
                            end else begin
                                tmo_cnt <= tmo_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                ST_CRC_HI: begin
                    if (cd_free) begin
                        cd_d     <= crc[15:8];
                        cd_d_rdy <= 1'b1;
                        state    <= ST_CRC_LO;
                    end
                end
                ST_CRC_LO: begin
                    if (cd_free) begin
                        cd_d      <= crc[7:0];
                        cd_d_rdy  <= 1'b1;
                        msg_end   <= 1'b1;
                        src_grant <= '0;
                        busy      <= 1'b0;
                        state     <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    src_grant <= '0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef HSI_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if ((state == ST_IDLE) && win_found) begin
            rr_ptr <= (win_idx == IDX_W'(N_SRC - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hsi_msg_arbiter.sv
module tb_hsi_msg_arbiter;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int TO = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   src_req = '0;
    logic [8*N-1:0] src_d = '0;
    logic [N-1:0]   src_d_rdy = '0;
    logic [N-1:0]   src_msg_end = '0;
    logic [N-1:0]   src_grant;
    logic [N-1:0]   src_busy;
    logic           cd_busy = 1'b0;
    logic [7:0]     cd_d;
    logic           cd_d_rdy;
    logic [IW-1:0]  grant_idx;
    logic           busy;
    logic           msg_end;
    logic           err;

    int errors = 0;
    int checks = 0;

    // Scoreboard queues: stimulus pushes, monitor pops.
    logic [7:0] exp_byte[$];
    int         exp_evt[$];     // 1 = msg_end, 2 = err
    int         exp_grant[$];   // expected granted source index
    logic [7:0] msg_buf[$];

    int rr_model = 0;
    int cd_lat   = 8;
    int cd_cnt   = 0;

    hsi_msg_arbiter #(
        .N_SRC    (N),
        .IDX_W    (IW),
        .TIMEOUT  (TO),
        .CRC_INIT (16'hFFFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_req     (src_req),
        .src_d       (src_d),
        .src_d_rdy   (src_d_rdy),
        .src_msg_end (src_msg_end),
        .src_grant   (src_grant),
        .src_busy    (src_busy),
        .cd_busy     (cd_busy),
        .cd_d        (cd_d),
        .cd_d_rdy    (cd_d_rdy),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .msg_end     (msg_end),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // CRC reference: bit-serial long division by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] req);
        int idx;
`ifdef HSI_ARB_RR_EN
        for (int k = 0; k < N; k++) begin
            idx = (rr_model + k) % N;
            if (req[idx]) begin
                rr_model = (idx + 1) % N;
                return idx;
            end
        end
`else
        for (int k = 0; k < N; k++) begin
            idx = k;
            if (req[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    // Coder model: busy for cd_lat cycles after each strobe.
    always begin
        @(posedge clk);
        #1;
        if (cd_d_rdy) cd_cnt = cd_lat;
        else if (cd_cnt > 0) cd_cnt = cd_cnt - 1;
        cd_busy = (cd_cnt > 0);
    end

    // Monitor
    logic [N-1:0] prev_grant = '0;
    always @(negedge clk) begin
        if (cd_d_rdy) begin
            if (exp_byte.size() == 0) begin
                checks++; errors++;
                $display("FAIL cd_byte: unexpected byte 0x%0h, none expected", cd_d);
            end else chk("cd_byte", {24'h0, cd_d}, {24'h0, exp_byte.pop_front()});
        end
        if (msg_end) begin
            if (exp_evt.size() == 0) begin
                checks++; errors++;
                $display("FAIL evt_msg_end: unexpected msg_end, no event expected");
            end else chk("evt_msg_end", 1, exp_evt.pop_front());
        end
        if (err) begin
            if (exp_evt.size() == 0) begin
                checks++; errors++;
                $display("FAIL evt_err: unexpected err, no event expected");
            end else chk("evt_err", 2, exp_evt.pop_front());
        end
        if (prev_grant == '0 && src_grant != '0) begin
            if (exp_grant.size() == 0) begin
                checks++; errors++;
                $display("FAIL grant: unexpected grant %b", src_grant);
            end else chk("grant_onehot", {28'h0, src_grant}, 32'd1 << exp_grant.pop_front());
        end
        prev_grant = src_grant;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_src_grant"}, {28'h0, src_grant}, 0);
        chk({tag, "_src_busy"},  {28'h0, src_busy}, 32'hF);
        chk({tag, "_cd_d"},      {24'h0, cd_d}, 0);
        chk({tag, "_cd_d_rdy"},  {31'h0, cd_d_rdy}, 0);
        chk({tag, "_grant_idx"}, {29'h0, grant_idx}, 0);
        chk({tag, "_busy"},      {31'h0, busy}, 0);
        chk({tag, "_msg_end"},   {31'h0, msg_end}, 0);
        chk({tag, "_err"},       {31'h0, err}, 0);
    endtask

    // mode: 0 end after bytes, 1 end with last byte, 2 timeout,
    //       3 overrun after first byte, 4 reset while waiting in CRC_HI
    task automatic run_msg(input logic [N-1:0] req, input int mode_in, input bit hold, input int exp_crc);
        int          w;
        int          n;
        int          t;
        int          mode;
        logic [15:0] crc;
        logic [15:0] crc_out;
        mode = mode_in;
        n = msg_buf.size();
        if (mode == 1 && n == 0) mode = 0;
        w = pick(req);
        exp_grant.push_back(w);
        src_req = req;
        t = 0;
        do begin @(negedge clk); t++; end while (src_grant == '0 && t < 40);
        if (src_grant == '0) begin
            checks++; errors++;
            $display("FAIL grant_wait: no grant after %0d cycles, req=%b", t, req);
            src_req = '0;
            return;
        end
        chk("grant_idx", {29'h0, grant_idx}, w);
        chk("busy_granted", {31'h0, busy}, 1);
        crc = 16'hFFFF;

        if (mode == 2) begin
            exp_evt.push_back(2);
            t = 0;
            while (!err && t < TO + 10) begin @(negedge clk); t++; end
            chk("timeout_cycles", t, TO + 1);
            chk("timeout_grant", {28'h0, src_grant}, 0);
            chk("timeout_busy", {31'h0, busy}, 0);
            if (!hold) src_req = '0;
            repeat (6) @(negedge clk);
            return;
        end

        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (src_busy[w] && t < 60) begin @(negedge clk); t++; end
            if (src_busy[w]) begin
                checks++; errors++;
                $display("FAIL src_free_wait: src_busy[%0d] stuck at 1", w);
                src_req = '0;
                return;
            end
            src_d[8*w +: 8] = msg_buf[i];
            src_d_rdy[w] = 1'b1;
            if (mode < 2) begin
                for (int j = 0; j < N; j++) begin
                    if (j != w && $urandom_range(0, 2) == 0) begin
                        src_d_rdy[j] = 1'b1;
                        src_d[8*j +: 8] = 8'($urandom);
                    end
                end
            end
            exp_byte.push_back(msg_buf[i]);
            crc = crc_model(crc, msg_buf[i]);
            if (i == n - 1 && (mode == 1 || mode == 4)) begin
                src_msg_end[w] = 1'b1;
                if (mode == 1) begin
                    crc_out = (exp_crc >= 0) ? exp_crc[15:0] : crc;
                    exp_byte.push_back(crc_out[15:8]);
                    exp_byte.push_back(crc_out[7:0]);
                    exp_evt.push_back(1);
                end
            end
            @(negedge clk);
            src_d_rdy = '0;
            src_msg_end = '0;
            if (mode == 3) begin
                chk("overrun_backpressure", {31'h0, src_busy[w]}, 1);
                src_d[8*w +: 8] = 8'h5A;
                src_d_rdy[w] = 1'b1;
                exp_evt.push_back(2);
                @(negedge clk);
                src_d_rdy = '0;
                chk("overrun_err", {31'h0, err}, 1);
                chk("overrun_grant", {28'h0, src_grant}, 0);
                chk("overrun_busy", {31'h0, busy}, 0);
                if (!hold) src_req = '0;
                repeat (6) @(negedge clk);
                return;
            end
        end

        if (mode == 4) begin
            @(negedge clk);
            chk("crc_hi_busy", {31'h0, busy}, 1);
            chk("crc_hi_no_strobe", {31'h0, cd_d_rdy}, 0);
            #1;
            rst = 1'b1;
            src_req = '0;
            @(negedge clk);
            chk_reset("rst_mid");
            rst = 1'b0;
            rr_model = 0;
            repeat (12) @(negedge clk);
            return;
        end

        if (mode == 0) begin
            src_msg_end[w] = 1'b1;
            crc_out = (exp_crc >= 0) ? exp_crc[15:0] : crc;
            exp_byte.push_back(crc_out[15:8]);
            exp_byte.push_back(crc_out[7:0]);
            exp_evt.push_back(1);
            @(negedge clk);
            src_msg_end = '0;
        end
        t = 0;
        while (!msg_end && t < 200) begin @(negedge clk); t++; end
        chk("msg_end_seen", {31'h0, msg_end}, 1);
        chk("guard_grant", {28'h0, src_grant}, 0);
        if (!hold) src_req = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'h0, busy}, 0);

        // Directed "123456789" from source 0, slow coder.
        cd_lat = 8;
        msg_buf = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_msg(4'b0001, 0, 1'b0, 32'h29B1);

        // Two sources requesting continuously for three messages.
        cd_lat = 2;
        for (int m = 0; m < 3; m++) begin
            msg_buf.delete();
            msg_buf.push_back(8'($urandom));
            msg_buf.push_back(8'($urandom));
            run_msg(4'b0110, 0, (m < 2), -1);
        end

        // Granted source never sends.
        msg_buf.delete();
        run_msg(4'b1000, 2, 1'b0, -1);

        // Byte strobed while back-pressured.
        cd_lat = 4;
        msg_buf = '{8'hA5};
        run_msg(4'b0100, 3, 1'b0, -1);

        // Single 0x00 byte coincident with msg_end.
        msg_buf = '{8'h00};
        run_msg(4'b0010, 1, 1'b0, 32'hE1F0);

        // Zero-length message: CRC of the preset only.
        msg_buf.delete();
        run_msg(4'b0001, 0, 1'b0, 32'hFFFF);

        // Randomized messages.
        for (int r = 0; r < 16; r++) begin
            logic [N-1:0] rq;
            int           nb;
            int           md;
            rq = 4'($urandom_range(1, 15));
            nb = $urandom_range(0, 5);
            md = (nb > 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
            cd_lat = $urandom_range(0, 8);
            msg_buf.delete();
            for (int b = 0; b < nb; b++) msg_buf.push_back(8'($urandom));
            run_msg(rq, md, 1'b0, -1);
        end

        // Reset while waiting to send the CRC high byte, then recovery.
        cd_lat = 8;
        msg_buf = '{8'h11, 8'h22};
        run_msg(4'b0001, 4, 1'b0, -1);
        cd_lat = 3;
        msg_buf = '{8'h5C, 8'hC5, 8'h0F};
        run_msg(4'b1010, 1, 1'b0, -1);

        repeat (20) @(negedge clk);
        chk("left_bytes", exp_byte.size(), 0);
        chk("left_events", exp_evt.size(), 0);
        chk("left_grants", exp_grant.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
